// File: rtl/muldiv_seq.sv
// Iterative RV32M unsigned multiply/divide sequencer built around one shared
// 32-bit adder: shift-add for MUL/MULHU, restoring subtract for DIVU/REMU.

module adder (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        car_in,
    output logic [31:0] result,
    output logic        car_out
);

    assign {car_out, result} = {1'b0, a_in} + {1'b0, b_in} + {32'b0, car_in};

endmodule

module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            start_in,
    input  logic [1:0]      op_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state, next_state;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [CNT_W-1:0]  cnt;

    logic              load;
    logic              is_div;
    logic              sub_taken;
    logic [XLEN-1:0]   shift_t;
    logic [XLEN-1:0]   add_a;
    logic [XLEN-1:0]   add_b;
    logic              add_cin;
    logic [XLEN-1:0]   add_sum;
    logic              add_cout;
    logic [XLEN-1:0]   hi_nxt;
    logic [XLEN-1:0]   lo_nxt;
    logic [XLEN-1:0]   res_nxt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start is honoured only outside CALC; DONE can hand straight over to a new op.
    always_comb begin
        next_state = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    next_state = CALC;
                    load       = 1'b1;
                end
            end
            CALC: begin
                busy_out = 1'b1;
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done_out = 1'b1;
                if (start_in) begin
                    next_state = CALC;
                    load       = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Divide subtracts via a + ~b + 1; multiply adds the multiplicand to hi.
    assign is_div  = op_q[1];
    assign shift_t = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
    assign add_a   = is_div ? shift_t : acc_hi;
    assign add_b   = is_div ? ~operand_q : operand_q;
    assign add_cin = is_div;

    adder u_adder (
        .a_in    (add_a),
        .b_in    (add_b),
        .car_in  (add_cin),
        .result  (add_sum),
        .car_out (add_cout)
    );

    // A set rem MSB means the shifted-out bit is worth 2^32, so the subtract always fits.
    assign sub_taken = add_cout | acc_hi[XLEN-1];

    always_comb begin
        hi_nxt = acc_hi;
        lo_nxt = acc_lo;
        if (is_div) begin
            hi_nxt = sub_taken ? add_sum : shift_t;
            lo_nxt = {acc_lo[XLEN-2:0], sub_taken};
        end else if (acc_lo[0]) begin
            hi_nxt = {add_cout, add_sum[XLEN-1:1]};
            lo_nxt = {add_sum[0], acc_lo[XLEN-1:1]};
        end else begin
            hi_nxt = {1'b0, acc_hi[XLEN-1:1]};
            lo_nxt = {acc_hi[0], acc_lo[XLEN-1:1]};
        end
    end

    assign res_nxt = op_q[0] ? hi_nxt : lo_nxt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            op_q       <= '0;
            operand_q  <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            cnt        <= '0;
            result_out <= '0;
        end else if (load) begin
            op_q      <= op_in;
            operand_q <= op_in[1] ? b_in : a_in;
            acc_hi    <= '0;
            acc_lo    <= op_in[1] ? a_in : b_in;
            cnt       <= '1;
        end else if (state == CALC) begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == '0) begin
                result_out <= res_nxt;
            end
        end
    end

endmodule
